vga_console_writer: RTL
=======================

// Module: vga_console_writer
//
// PURPOSE
//   Upstream feeder for the 40x30 VGA text/tile display. Accepts a byte stream
//   over a valid/ready handshake and turns it into video-RAM writes on the
//   display's write port (vram_waddr/vram_wdata/vram_we, clocked by clk).
//   Tracks a cursor, interprets a small control-code set, wraps at the screen
//   edges and clears cells in hardware (full screen, or a single line on wrap).
//
// PARAMETERS
//   COLS      40     cells per row; must be <= 64
//   ROWS      30     rows per screen; must be <= 32
//   AW        11     vram address width; COLS*ROWS must be <= 2**AW
//   BLANK     8'h20  value written to cleared cells
//
// PORTS
//   clk          in   1   single clock; also drives the vram write port
//   reset        in   1   asynchronous, active-high
//   in_data      in   8   byte to process
//   in_valid     in   1   in_data is valid
//   in_ready     out  1   block can accept; transfer = in_valid & in_ready
//   vram_waddr   out  AW  write address, row*COLS+col
//   vram_wdata   out  8   write data
//   vram_we      out  1   write strobe, one cell per cycle
//   cursor_col   out  6   current cursor column, 0..COLS-1
//   cursor_row   out  5   current cursor row, 0..ROWS-1
//   busy         out  1   a clear sequence is in progress
//
// BEHAVIOUR
//   - All outputs are registered, except in_ready = (state == IDLE).
//   - Reset values: state=CLEAR, clear counter=0, vram_we=0, vram_waddr=0,
//     vram_wdata=0, cursor=(0,0), busy=1. A reset at any point, including
//     mid-clear, restarts the full-screen clear from address 0.
//   - Address arithmetic: hold a row_base register equal to row*COLS. Update it
//     by +COLS per row, reset it to 0 on wrap. No multiplier.
//   - State IDLE: in_ready=1. On a transfer, the byte's effect is visible next
//     cycle. Any resulting write has vram_we=1 for exactly one cycle,
//     1 cycle after the accept.
//       0x20..0xFF printable: write in_data at (row,col).
//                 If col<COLS-1, col+1. Otherwise do a newline.
//       0x0D CR:  col=0. No write.
//       0x0A LF:  do a newline (col=0 included).
//       0x08 BS:  if col>0, col-1 and write BLANK at the new position.
//                 At col=0: no-op, no write.
//       0x0C FF:  go to CLEAR, cursor=(0,0).
//       other 0x00..0x1F: consumed, no effect.
//   - Newline: col=0. If row<ROWS-1, row+1; otherwise row=0. Then go to
//     CLRLINE for the new row.
//       * A printable byte at the last column is written first, in the accept
//         cycle+1.
//       * The line clear then starts on the following cycle.
//   - State CLRLINE: busy=1, in_ready=0.
//       * Writes BLANK to cols 0..COLS-1 of the cursor row, one per cycle,
//         vram_we held high for COLS consecutive cycles.
//       * Then returns to IDLE.
//       * For LF/CR-free wrap accepted at cycle N: clear writes occupy cycles
//         N+1..N+COLS, and in_ready=1 again at N+COLS+1.
//       * For a printable at the last column: char write at N+1, clear writes
//         at N+2..N+COLS+1, in_ready=1 again at N+COLS+2.
//   - State CLEAR: busy=1, in_ready=0.
//       * Writes BLANK to addresses 0..COLS*ROWS-1 ascending, one per cycle,
//         COLS*ROWS cycles of vram_we=1.
//       * Then IDLE with cursor (0,0).
//       * After reset release, the first write is on the first clock edge;
//         in_ready rises COLS*ROWS+1 cycles after release.
//   - vram_we=0 in every cycle without a write. vram_waddr/vram_wdata hold
//     their last values when idle.
//   - in_valid while in_ready=0: byte is not consumed. The upstream holds it,
//     and no data is lost or duplicated.
//   - Cursor outputs always reflect the position of the next printable write.
//
// TESTING
//   1. Reset, in_valid=0 -> exactly 1200 writes of 8'h20 to addrs 0..1199 in
//      order; in_ready=1 at cycle 1201; cursor=(0,0).
//   2. Send "AB" -> writes 0x41@0 then 0x42@1, each one cycle after its
//      accept; cursor_col=2.
//   3. cursor (5,3): send CR, LF -> cursor (0,4); 40 writes of 0x20 to
//      addrs 160..199; in_ready low for those 40 cycles.
//   4. cursor (39,29): send 0x58 -> write 0x58@1199, then 40 blanks @0..39,
//      cursor (0,0).
//   5. cursor (0,2): send BS -> no write. Then 'x', BS -> 0x78@80, 0x20@80,
//      cursor_col=0.
//   6. Hold in_valid with FF, pulse reset mid-clear at write #500 ->
//      clear restarts at addr 0; FF is consumed exactly once after
//      in_ready rises.

Source files
------------

// File: rtl/vga_console_writer.sv
// vga_console_writer: byte-stream console front end for the 40x30 text display.
// Accepts bytes over valid/ready and issues one video-RAM write per cycle:
// printable characters, backspace blanks, single-line clears on newline and
// full-screen clears on reset or form feed.
module vga_console_writer #(
    parameter int         COLS  = 40,
    parameter int         ROWS  = 30,
    parameter int         AW    = 11,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [AW-1:0] vram_waddr,
    output logic [7:0]    vram_wdata,
    output logic          vram_we,
    output logic [5:0]    cursor_col,
    output logic [4:0]    cursor_row,
    output logic          busy
);

    localparam int CELLS = COLS * ROWS;

    typedef enum logic [1:0] {
        IDLE,
        CLRLINE,
        CLEAR
    } state_t;

    state_t        state;
    logic [AW:0]   cnt;        // clear progress; one bit wider so CELLS == 2**AW still terminates
    logic [AW-1:0] row_base;   // always cursor_row * COLS
    logic          accept;
    logic [4:0]    nl_row;
    logic [AW-1:0] nl_base;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    // Row and row base that a newline moves the cursor to (wraps to the top).
    always_comb begin
        nl_row  = '0;
        nl_base = '0;
        if (cursor_row != 5'(ROWS - 1)) begin
            nl_row  = cursor_row + 5'd1;
            nl_base = row_base + AW'(COLS);
        end
    end

    // Main controller: byte interpretation, cursor tracking and clear sequencing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CLEAR;
            cnt        <= '0;
            row_base   <= '0;
            vram_we    <= 1'b0;
            vram_waddr <= '0;
            vram_wdata <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
            busy       <= 1'b1;
        end else begin
            vram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_data >= 8'h20) begin
                            vram_we    <= 1'b1;
                            vram_waddr <= row_base + AW'(cursor_col);
                            vram_wdata <= in_data;
                            if (cursor_col != 6'(COLS - 1)) begin
                                cursor_col <= cursor_col + 6'd1;
                            end else begin
                                // Character goes out now; the line clear starts
                                // from column 0 on the next cycle.
                                cursor_col <= '0;
                                cursor_row <= nl_row;
                                row_base   <= nl_base;
                                cnt        <= '0;
                                busy       <= 1'b1;
                                state      <= CLRLINE;
                            end
                        end else begin
                            case (in_data)
                                8'h0D: cursor_col <= '0;
                                8'h0A: begin
                                    // Column 0 of the new row is blanked in the
                                    // accept cycle itself, so the clear resumes at 1.
                                    cursor_col <= '0;
                                    cursor_row <= nl_row;
                                    row_base   <= nl_base;
                                    vram_we    <= 1'b1;
                                    vram_waddr <= nl_base;
                                    vram_wdata <= BLANK;
                                    cnt        <= (AW+1)'(1);
                                    busy       <= 1'b1;
                                    state      <= CLRLINE;
                                end
                                8'h08: begin
                                    if (cursor_col != '0) begin
                                        cursor_col <= cursor_col - 6'd1;
                                        vram_we    <= 1'b1;
                                        vram_waddr <= row_base + AW'(cursor_col - 6'd1);
                                        vram_wdata <= BLANK;
                                    end
                                end
                                8'h0C: begin
                                    cursor_col <= '0;
                                    cursor_row <= '0;
                                    row_base   <= '0;
                                    cnt        <= '0;
                                    busy       <= 1'b1;
                                    state      <= CLEAR;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                CLRLINE: begin
                    if (cnt == (AW+1)'(COLS)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        vram_we    <= 1'b1;
                        vram_waddr <= row_base + cnt[AW-1:0];
                        vram_wdata <= BLANK;
                        cnt        <= cnt + 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == (AW+1)'(CELLS)) begin
                        cursor_col <= '0;
                        cursor_row <= '0;
                        row_base   <= '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        vram_we    <= 1'b1;
                        vram_waddr <= cnt[AW-1:0];
                        vram_wdata <= BLANK;
                        cnt        <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule
